pll_lock_supervisor: RTL and testbench

Parametrised supervisor for the board PLL, running on the free-running reference clock. It drives the PLL reset and qualifies the PLL `locked` flag with a debounce window. It releases `NUM_CH` downstream clock-domain resets in a staggered order, and on loss of lock it re-asserts those resets and re-arms the PLL. It also keeps a saturating lock-loss count and a sticky lock-timeout flag, for use by software or status LEDs.

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/pll_lock_supervisor_sync_2ff.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 199 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_sup_state_t;

    // Width of the shared cycle counter: it must hold (largest period - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLL lock flag.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both clear to 0 so lock is never assumed after reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: PLL reset pulse, lock debounce, staggered channel
// reset release, loss re-arm, saturating loss counter.
// Optional feature macro PLL_SUP_TIMEOUT_EN: lock timeout retry and sticky
// timeout_err. Without it WAIT_LOCK waits forever and timeout_err is 0.
//
// state     | meaning
// PLL_RST   | pll_rst high for PLL_RST_CYC cycles
// WAIT_LOCK | waiting for synchronised lock (optionally with timeout)
// STABLE    | counting consecutive locked cycles (debounce)
// RELEASE   | releasing channels one per RELEASE_GAP_CYC
// RUN       | all channels released, ready high
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned PLL_RST_CYC      = 8,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned RELEASE_GAP_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
    parameter int unsigned LOSS_CNT_W       = 8
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  clr,
    output logic                  pll_rst,
    output logic [NUM_CH-1:0]     ch_rst_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYC, LOCK_STABLE_CYC,
                                              RELEASE_GAP_CYC, LOCK_TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(RELEASE_GAP_CYC - 1);
`ifdef PLL_SUP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_TC   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
`endif
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

    pll_sup_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0]     ch_q, ch_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic [NUM_CH-1:0]     ch_next;
    logic                  locked_s;
    logic                  loss_evt;
    logic                  tout_evt;

    sync_2ff u_sync (
        .clk_i (refclk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // Thermometer step: releases the next channel in index order.
    assign ch_next = (ch_q << 1) | NUM_CH'(1);

    // Next-state and registered-output decode; one shared cycle counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pll_rst_d = pll_rst_q;
        ch_d      = ch_q;
        ready_d   = ready_q;
        loss_evt  = 1'b0;
        tout_evt  = 1'b0;
        case (state_q)
            PLL_RST: begin
                pll_rst_d = 1'b1;
                if (cnt_q == RST_TC) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_SUP_TIMEOUT_EN
                else if (cnt_q == TOUT_TC) begin
                    tout_evt  = 1'b1;
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_TC) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    ch_d    = ch_next;
                    if (&ch_next) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    loss_evt  = 1'b1;
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    ch_d      = '0;
                    ready_d   = 1'b0;
                end else if (state_q == RELEASE) begin
                    if (cnt_q == GAP_TC) begin
                        cnt_d = '0;
                        ch_d  = ch_next;
                        if (&ch_next) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d   = PLL_RST;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
                ch_d      = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // Saturating loss counter; clr takes priority over a same-cycle loss.
    always_comb begin
        loss_d = loss_q;
        if (clr)
            loss_d = '0;
        else if (loss_evt && !(&loss_q))
            loss_d = loss_q + LOSS_ONE;
    end

    // FSM state, shared counter and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ch_q      <= '0;
            ready_q   <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            ch_q      <= ch_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
        end
    end

`ifdef PLL_SUP_TIMEOUT_EN
    logic tout_q;

    // Sticky timeout flag; clr wins over a same-cycle timeout.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            tout_q <= 1'b0;
        else if (clr)
            tout_q <= 1'b0;
        else if (tout_evt)
            tout_q <= 1'b1;
    end

    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign pll_rst  = pll_rst_q;
    assign ch_rst_n = ch_q;
    assign ready    = ready_q;
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (NUM_CH=3, PLL_RST_CYC=4,
// LOCK_STABLE_CYC=8, RELEASE_GAP_CYC=4, LOCK_TIMEOUT_CYC=32, LOSS_CNT_W=2).
// Timeout checks follow PLL_SUP_TIMEOUT_EN.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       clr;
    logic       pll_rst;
    logic [2:0] ch_rst_n;
    logic       ready;
    logic [1:0] loss_cnt;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    pll_lock_supervisor #(
        .NUM_CH           (3),
        .PLL_RST_CYC      (4),
        .LOCK_STABLE_CYC  (8),
        .RELEASE_GAP_CYC  (4),
        .LOCK_TIMEOUT_CYC (32),
        .LOSS_CNT_W       (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .clr         (clr),
        .pll_rst     (pll_rst),
        .ch_rst_n    (ch_rst_n),
        .ready       (ready),
        .loss_cnt    (loss_cnt),
        .timeout_err (timeout_err)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic steps(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, {7'd0, pll_rst}, 8'd1);
        chk({tag, "_ch"}, {5'd0, ch_rst_n}, 8'd0);
        chk({tag, "_ready"}, {7'd0, ready}, 8'd0);
        chk({tag, "_loss"}, {6'd0, loss_cnt}, 8'd0);
        chk({tag, "_tout"}, {7'd0, timeout_err}, 8'd0);
    endtask

    // Called in RUN: drop lock and check the loss lands on the 3rd edge.
    task automatic lose(input logic [1:0] exp_loss);
        pll_locked = 1'b0;
        steps(2);
        chk("loss_ch_hold", {5'd0, ch_rst_n}, 8'h07);
        steps(1);
        chk("loss_ch", {5'd0, ch_rst_n}, 8'h00);
        chk("loss_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("loss_ready", {7'd0, ready}, 8'd0);
        chk("loss_cnt", {6'd0, loss_cnt}, {6'd0, exp_loss});
    endtask

    // Called right after a loss: wait out the PLL reset, relock, reach RUN.
    task automatic relock();
        steps(3);
        chk("rearm_pll_rst_hi", {7'd0, pll_rst}, 8'd1);
        steps(1);
        chk("rearm_pll_rst_lo", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        steps(19);
        chk("relock_ch", {5'd0, ch_rst_n}, 8'h07);
        chk("relock_ready", {7'd0, ready}, 8'd1);
    endtask

    initial begin
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        clr        = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("por");
        steps(2);
        rst_n = 1'b0;
        steps(0);
        rst_n = 1'b1;

        // Clean bring-up
        steps(3);
        chk("bu_pll_rst_3", {7'd0, pll_rst}, 8'd1);
        steps(1);
        chk("bu_pll_rst_4", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        steps(10);
        chk("bu_ch0_early", {5'd0, ch_rst_n}, 8'h00);
        steps(1);
        chk("bu_ch0", {5'd0, ch_rst_n}, 8'h01);
        steps(3);
        chk("bu_ch1_early", {5'd0, ch_rst_n}, 8'h01);
        steps(1);
        chk("bu_ch1", {5'd0, ch_rst_n}, 8'h03);
        steps(3);
        chk("bu_ch2_early", {5'd0, ch_rst_n}, 8'h03);
        chk("bu_ready_early", {7'd0, ready}, 8'd0);
        steps(1);
        chk("bu_ch2", {5'd0, ch_rst_n}, 8'h07);
        chk("bu_ready", {7'd0, ready}, 8'd1);

        // Loss in RUN, then debounce glitch during relock
        lose(2'd1);
        steps(3);
        chk("l1_pll_rst_hi", {7'd0, pll_rst}, 8'd1);
        steps(1);
        chk("l1_pll_rst_lo", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        steps(7);
        pll_locked = 1'b0;
        steps(1);
        pll_locked = 1'b1;
        steps(1);
        chk("db_no_rel", {5'd0, ch_rst_n}, 8'h00);
        steps(9);
        chk("db_ch0_early", {5'd0, ch_rst_n}, 8'h00);
        chk("db_loss_uncounted", {6'd0, loss_cnt}, 8'd1);
        steps(1);
        chk("db_ch0", {5'd0, ch_rst_n}, 8'h01);
        steps(8);
        chk("db_run_ch", {5'd0, ch_rst_n}, 8'h07);
        chk("db_run_ready", {7'd0, ready}, 8'd1);

        // Timeout
        lose(2'd2);
        steps(4);
        chk("to_wait_entry", {7'd0, pll_rst}, 8'd0);
`ifdef PLL_SUP_TIMEOUT_EN
        steps(31);
        chk("to_err_early", {7'd0, timeout_err}, 8'd0);
        chk("to_pll_rst_early", {7'd0, pll_rst}, 8'd0);
        steps(1);
        chk("to_err", {7'd0, timeout_err}, 8'd1);
        chk("to_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("to_not_loss", {6'd0, loss_cnt}, 8'd2);
        steps(3);
        chk("to_retry_hi", {7'd0, pll_rst}, 8'd1);
        steps(1);
        chk("to_retry_lo", {7'd0, pll_rst}, 8'd0);
`else
        steps(40);
        chk("to_no_retry", {7'd0, pll_rst}, 8'd0);
        chk("to_err_tied", {7'd0, timeout_err}, 8'd0);
`endif
        pll_locked = 1'b1;
        steps(19);
        chk("to_relock_ch", {5'd0, ch_rst_n}, 8'h07);
        chk("to_relock_ready", {7'd0, ready}, 8'd1);

        // Saturation and clear
        lose(2'd3);
        relock();
        lose(2'd3);
        relock();
        pll_locked = 1'b0;
        steps(2);
        clr = 1'b1;
        steps(1);
        clr = 1'b0;
        chk("clr_loss", {6'd0, loss_cnt}, 8'd0);
        chk("clr_tout", {7'd0, timeout_err}, 8'd0);
        chk("clr_ch", {5'd0, ch_rst_n}, 8'h00);

        // Reset mid-RELEASE
        steps(4);
        chk("mr_pll_rst_lo", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        steps(11);
        chk("mr_ch0", {5'd0, ch_rst_n}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mr_async");
        steps(2);
        rst_n = 1'b1;
        steps(3);
        chk("mr_pll_rst_hi", {7'd0, pll_rst}, 8'd1);
        steps(1);
        chk("mr_pll_rst_lo2", {7'd0, pll_rst}, 8'd0);
        steps(8);
        chk("mr_ch0_early", {5'd0, ch_rst_n}, 8'h00);
        steps(1);
        chk("mr_ch0_rel", {5'd0, ch_rst_n}, 8'h01);
        steps(8);
        chk("mr_full_ch", {5'd0, ch_rst_n}, 8'h07);
        chk("mr_full_ready", {7'd0, ready}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
